// File: rtl/fp32_to_int32_conv.sv
`default_nettype none
// ============================================================================
// Module      : fp32_to_int32_conv
// Description : Multi-cycle IEEE-754 binary32 to signed 32-bit integer
//               converter. The operand is unpacked into sign / exponent /
//               significand, aligned to the integer binary point, rounded
//               (nearest-even or toward zero) using a guard/sticky pair,
//               and finally negated into two's complement. Out-of-range,
//               NaN and infinite inputs saturate and raise the invalid flag.
//               One conversion is in flight at a time; both sides use a
//               valid/ready handshake.
//
// Ports       : clk         - clock, rising edge
//               rst         - synchronous reset, active high
//               in_valid    - in_data/command valid
//               in_ready    - converter can accept an operand
//               in_data     - FP32 operand {sign, exp[7:0], frac[22:0]}
//               command     - 1 = round to nearest even, 0 = truncate
//               out_valid   - result valid
//               out_ready   - consumer accepts the result
//               out_data    - signed integer result
//               out_inexact - discarded fraction bits were nonzero
//               out_invalid - NaN / Inf / out-of-range, result saturated
//
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_to_int32_conv #(
    parameter int BIAS  = 127,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        command,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact,
    output logic        out_invalid
);

    // ------------------------------------------------------------------
    // Format constants
    // ------------------------------------------------------------------
    localparam int c_EXP_W = 31 - MAN_W;          // exponent field width
    localparam int c_SIG_W = MAN_W + 1;           // significand incl. hidden bit
    localparam int c_EXT_W = 2 * c_SIG_W;         // significand + shifted-out bits

    localparam logic [c_EXP_W-1:0] c_EXP_MAX    = '1;
    // Exponent at which the significand LSB has weight 2^0.
    localparam logic [c_EXP_W-1:0] c_EXP_EXACT  = c_EXP_W'(BIAS + MAN_W);
    // Exponent at which the magnitude reaches 2^31.
    localparam logic [c_EXP_W-1:0] c_EXP_SAT    = c_EXP_W'(BIAS + 31);
    // Largest right shift that still leaves bits inside the extended word.
    localparam logic [c_EXP_W-1:0] c_RSHIFT_MAX = c_EXP_W'(c_SIG_W);

    localparam logic [31:0] c_POS_SAT = 32'h7FFF_FFFF;
    localparam logic [31:0] c_NEG_SAT = 32'h8000_0000;

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ROUND = 3'd2,
        S_PACK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------
    // Operand and datapath registers
    // ------------------------------------------------------------------
    logic               r_sign;
    logic [c_EXP_W-1:0] r_exp;
    logic [c_SIG_W-1:0] r_sig;
    logic               r_frac_nz;   // stored fraction nonzero (NaN / denormal)
    logic               r_cmd;

    logic [31:0]        r_mag;
    logic               r_guard;
    logic               r_sticky;
    logic               r_sat;
    logic [31:0]        r_sat_val;
    logic               r_invalid;
    logic               r_inexact;

    // Output registers
    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic               r_out_inexact;
    logic               r_out_invalid;

    // ------------------------------------------------------------------
    // Alignment (combinational, registered in ALIGN)
    // ------------------------------------------------------------------
    logic [c_EXP_W-1:0] w_rshift;
    logic [c_EXP_W-1:0] w_lshift;
    logic [c_EXT_W-1:0] w_ext;
    logic [31:0]        w_mag;
    logic               w_guard;
    logic               w_sticky;
    logic               w_sat;
    logic [31:0]        w_sat_val;
    logic               w_invalid;

    assign w_rshift = c_EXP_EXACT - r_exp;
    assign w_lshift = r_exp - c_EXP_EXACT;

    // The significand is placed in the upper half of a double-width word so
    // a right shift moves the discarded bits into the lower half: its MSB
    // becomes the guard bit and the remainder folds into sticky.
    assign w_ext = {r_sig, {c_SIG_W{1'b0}}} >> w_rshift;

    always_comb begin
        w_mag     = '0;
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        w_sat     = 1'b0;
        w_sat_val = c_POS_SAT;
        w_invalid = 1'b0;

        if (r_exp == c_EXP_MAX) begin
            // NaN and +Inf go positive; only -Inf saturates negative.
            w_sat     = 1'b1;
            w_invalid = 1'b1;
            w_sat_val = (r_sign && !r_frac_nz) ? c_NEG_SAT : c_POS_SAT;
        end else if (r_exp >= c_EXP_SAT) begin
            // Magnitude >= 2^31. Exactly -2^31 is representable, so it takes
            // the saturation value but is not flagged.
            w_sat     = 1'b1;
            w_sat_val = r_sign ? c_NEG_SAT : c_POS_SAT;
            w_invalid = !(r_exp == c_EXP_SAT && !r_frac_nz && r_sign);
        end else if (r_exp >= c_EXP_EXACT) begin
            // Integer-valued input: left shift of at most 7, no fraction lost.
            w_mag = 32'(r_sig) << w_lshift;
        end else if (w_rshift <= c_RSHIFT_MAX) begin
            w_mag    = 32'(w_ext[c_EXT_W-1 -: c_SIG_W]);
            w_guard  = w_ext[c_SIG_W-1];
            w_sticky = |w_ext[c_SIG_W-2:0];
        end else begin
            // Everything shifts out below the guard position. A denormal has
            // a zero significand here but a nonzero fraction, so it still
            // contributes to sticky.
            w_sticky = (r_exp != '0) | r_frac_nz;
        end
    end

    // Round-to-nearest-even increment: above half, or exactly half with an
    // odd integer part.
    logic w_increment;
    assign w_increment = r_cmd & r_guard & (r_sticky | r_mag[0]);

    // ------------------------------------------------------------------
    // Control and datapath sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_sig         <= '0;
            r_frac_nz     <= 1'b0;
            r_cmd         <= 1'b0;
            r_mag         <= '0;
            r_guard       <= 1'b0;
            r_sticky      <= 1'b0;
            r_sat         <= 1'b0;
            r_sat_val     <= '0;
            r_invalid     <= 1'b0;
            r_inexact     <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
            r_out_invalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign     <= in_data[31];
                        r_exp      <= in_data[30:MAN_W];
                        r_sig      <= (in_data[30:MAN_W] != '0)
                                      ? {1'b1, in_data[MAN_W-1:0]}
                                      : '0;
                        r_frac_nz  <= |in_data[MAN_W-1:0];
                        r_cmd      <= command;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ALIGN;
                    end
                end

                S_ALIGN: begin
                    r_mag     <= w_mag;
                    r_guard   <= w_guard;
                    r_sticky  <= w_sticky;
                    r_sat     <= w_sat;
                    r_sat_val <= w_sat_val;
                    r_invalid <= w_invalid;
                    r_state   <= S_ROUND;
                end

                S_ROUND: begin
                    // Rounding only happens below the exact-integer exponent,
                    // where the magnitude is < 2^24, so this cannot overflow.
                    r_mag     <= r_mag + 32'(w_increment);
                    r_inexact <= !r_sat & (r_guard | r_sticky);
                    r_state   <= S_ROUND == S_ROUND ? S_PACK : S_PACK;
                end

                S_PACK: begin
                    if (r_sat) begin
                        r_out_data <= r_sat_val;
                    end else begin
                        r_out_data <= r_sign ? (~r_mag + 32'd1) : r_mag;
                    end
                    r_out_inexact <= r_inexact;
                    r_out_invalid <= r_invalid;
                    r_out_valid   <= 1'b1;
                    r_state       <= S_DONE;
                end

                S_DONE: begin
                    // Result and flags hold until consumed; after the
                    // handshake out_data/flags keep their last value.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;
    assign out_invalid = r_out_invalid;

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int32_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_to_int32_conv
// Description : Self-checking bench for fp32_to_int32_conv. Expected results
//               come from a real-arithmetic reference model of the FP32 to
//               int32 conversion rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_to_int32_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        command = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_inexact;
    logic        out_invalid;

    int n_cmp  = 0;
    int n_fail = 0;

    fp32_to_int32_conv #(
        .BIAS  (127),
        .MAN_W (23)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .command     (command),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact),
        .out_invalid (out_invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: evaluates the real value of the operand and applies
    // the truncate / round-half-even / saturation rules to it directly.
    task automatic model(input logic [31:0] x, input logic cmd,
                         output logic [31:0] d, output logic inex, output logic inv);
        int    e;
        real   v;
        real   fr;
        int    t;
        real   two31;
        logic  sgn;
        sgn   = x[31];
        e     = int'(x[30:23]);
        two31 = 2147483648.0;
        d     = 32'd0;
        inex  = 1'b0;
        inv   = 1'b0;
        if (e == 255) begin
            inv = 1'b1;
            d   = (x[22:0] != 0 || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else begin
            if (e == 0) begin
                v = real'(x[22:0]);
                e = 1;
            end else begin
                v = real'({1'b1, x[22:0]});
            end
            // value = significand * 2^(e - 150)
            if (e > 150) begin
                for (int i = 0; i < e - 150; i++) v = v * 2.0;
            end else begin
                for (int i = 0; i < 150 - e; i++) v = v / 2.0;
            end
            if (v >= two31) begin
                if (sgn && v == two31) begin
                    d = 32'h8000_0000;
                end else begin
                    inv = 1'b1;
                    d   = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end
            end else begin
                t    = $rtoi(v);
                fr   = v - real'(t);
                inex = (fr != 0.0);
                if (cmd && (fr > 0.5 || (fr == 0.5 && (t % 2) == 1))) t = t + 1;
                d = sgn ? 32'(-t) : 32'(t);
            end
        end
    endtask

    // Runs one conversion starting from an idle negedge; returns at the
    // negedge after the result was consumed.
    task automatic conv(input logic [31:0] x, input logic cmd, input string tag);
        logic [31:0] ed;
        logic        ei;
        logic        ev;
        model(x, cmd, ed, ei, ev);
        chk({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        in_data   = x;
        command   = cmd;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        command  = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            chk({tag, " out_valid early"}, {31'd0, out_valid}, 32'd0);
            chk({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, " data"}, out_data, ed);
        chk({tag, " inexact"}, {31'd0, out_inexact}, {31'd0, ei});
        chk({tag, " invalid"}, {31'd0, out_invalid}, {31'd0, ev});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        logic [7:0]  e;
        int          cls;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_data", out_data, 32'd0);
        chk("rst inexact", {31'd0, out_inexact}, 32'd0);
        chk("rst invalid", {31'd0, out_invalid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        conv(32'h40490FDB, 1'b1, "pi rne");
        conv(32'h40200000, 1'b1, "2.5 rne");
        conv(32'h40600000, 1'b1, "3.5 rne");
        conv(32'h40600000, 1'b0, "3.5 trunc");
        conv(32'hBF000000, 1'b1, "-0.5");
        conv(32'hBF400000, 1'b1, "-0.75");
        conv(32'h80000000, 1'b1, "-0.0");
        conv(32'h00000001, 1'b1, "denorm");
        conv(32'hCF000000, 1'b1, "-2^31");
        conv(32'h4F000000, 1'b1, "2^31");
        conv(32'h7FC00000, 1'b1, "nan");
        conv(32'hFFC00001, 1'b0, "neg nan");
        conv(32'hFF800000, 1'b1, "-inf");
        conv(32'h7F800000, 1'b0, "+inf");
        conv(32'h4B7FFFFF, 1'b1, "2^24-1");
        conv(32'h4EFFFFFF, 1'b1, "max exp157");
        conv(32'hCEFFFFFF, 1'b0, "min exp157");
        conv(32'hCF000001, 1'b1, "below -2^31");
        conv(32'h3FC00000, 1'b1, "1.5 rne");
        conv(32'h3FC00000, 1'b0, "1.5 trunc");
        conv(32'h4B000001, 1'b1, "2^23+1");
        conv(32'h4AFFFFFF, 1'b1, "half ulp tie");
        conv(32'h3EFFFFFF, 1'b1, "just below half");

        // Backpressure: result held while a new operand waits
        in_data  = 32'h40490FDB;
        command  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        in_data  = 32'hC0600000;
        command  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold valid", {31'd0, out_valid}, 32'd1);
            chk("bp hold data", out_data, 32'd3);
            chk("bp hold inexact", {31'd0, out_inexact}, 32'd1);
            chk("bp hold invalid", {31'd0, out_invalid}, 32'd0);
            chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release valid", {31'd0, out_valid}, 32'd0);
        chk("bp not taken in DONE", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp taken in IDLE", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bp second early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bp second valid", {31'd0, out_valid}, 32'd1);
        chk("bp second data", out_data, 32'hFFFF_FFFC);
        chk("bp second inexact", {31'd0, out_inexact}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while the operand sits in ROUND
        in_data  = 32'h4B7FFFFF;
        command  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst out_data", out_data, 32'd0);
        chk("midrst inexact", {31'd0, out_inexact}, 32'd0);
        chk("midrst invalid", {31'd0, out_invalid}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst no emit", {31'd0, out_valid}, 32'd0);
        end

        // Randomized operands, biased toward interesting exponents
        for (int n = 0; n < 150; n++) begin
            cls = int'($urandom_range(0, 3));
            case (cls)
                0:       e = 8'($urandom_range(118, 160));
                1:       e = 8'($urandom_range(0, 255));
                2:       e = 8'($urandom_range(126, 152));
                default: e = 8'($urandom_range(155, 159));
            endcase
            x = {1'($urandom), e, 23'($urandom)};
            if (cls == 2 && $urandom_range(0, 1) == 1) begin
                // Force an exact tie pattern below the binary point.
                x[22:0] = {x[22:10], 10'b1000000000};
                x[30:23] = 8'd140;
            end
            conv(x, 1'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
